// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo
// Receive-side byte buffer between the UART receiver and the command
// interface. Bytes strobed in by rx_done are stored in a circular buffer
// and presented first-word-fall-through to the consumer, which pops them
// with rd_en. Bytes arriving while the buffer is full, with no pop in the
// same cycle, are dropped and latch the sticky overflow flag.
//
// Optional feature macro: RX_FIFO_LEVEL_EN
//   When defined, adds level (current occupancy) and almost_full
//   (occupancy >= DEPTH-2) outputs.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   rx_done        one-cycle write strobe; d_in is valid in the same cycle
//   d_in           received byte
//   rd_en          consumer pop request (ignored while empty)
//   d_out          head-of-queue byte, 0 when empty
//   data_valid     buffer non-empty
//   full           buffer holds DEPTH bytes
//   overflow       sticky: at least one byte was dropped
//   clear_overflow synchronous clear of overflow (a same-cycle drop wins)
//   level          (RX_FIFO_LEVEL_EN) occupancy count
//   almost_full    (RX_FIFO_LEVEL_EN) occupancy >= DEPTH-2
module rx_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] d_out,
  output logic              data_valid,
  output logic              full,
  output logic              overflow,
`ifdef RX_FIFO_LEVEL_EN
  input  logic              clear_overflow,
  output logic [ADDR_W:0]   level,
  output logic              almost_full
`else
  input  logic              clear_overflow
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   CNT_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  logic we;
  logic pop;
  logic drop;

  assign data_valid = (count != '0);
  assign full       = (count == CNT_DEPTH);

  // A pop in the same cycle frees a slot, so a write into a full buffer is
  // still accepted when the consumer is draining.
  assign pop  = rd_en & data_valid;
  assign we   = rx_done & (~full | pop);
  assign drop = rx_done & full & ~pop;

  assign d_out = data_valid ? mem[rd_ptr] : '0;

`ifdef RX_FIFO_LEVEL_EN
  assign level       = count;
  assign almost_full = (count >= (CNT_DEPTH - CNT_ONE - CNT_ONE));
`endif

  // Control state: pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({we, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Set has priority over clear so a drop is never hidden.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage: not reset; writes are blocked while reset is asserted
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[wr_ptr] <= d_in;
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed testbench for rx_byte_fifo: reset, single write, fill/drain
// ordering, overflow set/clear, full with simultaneous write and pop,
// pointer wrap against a queue model, empty pop and reset mid-operation.
module tb_rx_byte_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       rd_en = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [7:0] d_out;
  logic       data_valid;
  logic       full;
  logic       overflow;
`ifdef RX_FIFO_LEVEL_EN
  logic [4:0] level;
  logic       almost_full;
`endif

  int n_vec = 0;
  int n_err = 0;

  rx_byte_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_done        (rx_done),
    .d_in           (d_in),
    .rd_en          (rd_en),
    .d_out          (d_out),
    .data_valid     (data_valid),
    .full           (full),
    .overflow       (overflow),
`ifdef RX_FIFO_LEVEL_EN
    .clear_overflow (clear_overflow),
    .level          (level),
    .almost_full    (almost_full)
`else
    .clear_overflow (clear_overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_done = 1'b1;
    d_in    = b;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [7:0] q[$];
  logic       m_pop;
  logic       m_we;
  int         n_wr;

  initial begin
    #1;
    // Reset state
    do_reset();
    check_eq("rst_dv", data_valid, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_dout", d_out, 0);
    check_eq("rst_ovf", overflow, 0);
`ifdef RX_FIFO_LEVEL_EN
    check_eq("rst_level", level, 0);
    check_eq("rst_af", almost_full, 0);
`endif

    // Single write, one-cycle visibility, then pop back to empty
    push(8'hA5);
    check_eq("w1_dv", data_valid, 1);
    check_eq("w1_dout", d_out, 8'hA5);
    check_eq("w1_full", full, 0);
    pop_one();
    check_eq("p1_dv", data_valid, 0);
    check_eq("p1_dout", d_out, 0);

    // Fill 00..0F
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (i == 14) check_eq("fill15_full", full, 0);
`ifdef RX_FIFO_LEVEL_EN
      if (i == 12) begin
        check_eq("lvl13", level, 13);
        check_eq("af13", almost_full, 0);
      end
      if (i == 13) begin
        check_eq("lvl14", level, 14);
        check_eq("af14", almost_full, 1);
      end
`endif
    end
    check_eq("fill_full", full, 1);
    check_eq("fill_head", d_out, 8'h00);

    // Drop while full
    push(8'hEE);
    check_eq("drop_ovf", overflow, 1);
    check_eq("drop_full", full, 1);
    check_eq("drop_head", d_out, 8'h00);
`ifdef RX_FIFO_LEVEL_EN
    check_eq("drop_lvl", level, 16);
`endif
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_eq("clr_ovf", overflow, 0);
    // Clear and drop together: set wins
    clear_overflow = 1'b1;
    push(8'hEE);
    clear_overflow = 1'b0;
    check_eq("clrdrop_ovf", overflow, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_eq("clr2_ovf", overflow, 0);

    // Drain: exact order, no EE
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("drain_dv%0d", i), data_valid, 1);
      check_eq($sformatf("drain_d%0d", i), d_out, 8'(i));
      pop_one();
    end
    check_eq("drain_empty", data_valid, 0);
    check_eq("drain_full", full, 0);

    // Full with simultaneous write and pop
    for (int i = 0; i < 16; i++) push(8'(i));
    rx_done = 1'b1;
    d_in    = 8'h77;
    rd_en   = 1'b1;
    tick();
    rx_done = 1'b0;
    rd_en   = 1'b0;
    check_eq("wp_full", full, 1);
    check_eq("wp_ovf", overflow, 0);
    check_eq("wp_head", d_out, 8'h01);
    for (int i = 1; i < 16; i++) begin
      check_eq($sformatf("wp_d%0d", i), d_out, 8'(i));
      pop_one();
    end
    check_eq("wp_last", d_out, 8'h77);
    pop_one();
    check_eq("wp_empty", data_valid, 0);

    // Count==1 with simultaneous write and pop: new byte becomes head
    push(8'h31);
    rx_done = 1'b1;
    d_in    = 8'h32;
    rd_en   = 1'b1;
    tick();
    rx_done = 1'b0;
    rd_en   = 1'b0;
    check_eq("c1_dv", data_valid, 1);
    check_eq("c1_head", d_out, 8'h32);
    pop_one();
    check_eq("c1_empty", data_valid, 0);

    // Wrap: 40 writes interleaved with pops, checked against a queue
    n_wr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (n_wr >= 40 && q.size() == 0) break;
      rx_done = (n_wr < 40) && ((cyc % 5) != 3) && ((cyc % 7) != 6);
      d_in    = 8'(8'h40 + n_wr);
      rd_en   = ((cyc % 3) != 0) || (n_wr >= 40);
      check_eq("wrap_dv", data_valid, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) check_eq("wrap_d", d_out, q[0]);
      m_pop = rd_en && (q.size() != 0);
      m_we  = rx_done && ((q.size() < 16) || m_pop);
      if (m_pop) void'(q.pop_front());
      if (m_we) begin
        q.push_back(d_in);
        n_wr++;
      end
      tick();
    end
    rx_done = 1'b0;
    rd_en   = 1'b0;
    check_eq("wrap_count", n_wr, 40);
    check_eq("wrap_done_dv", data_valid, 0);

    // Pop while empty is ignored
    pop_one();
    check_eq("epop_dv", data_valid, 0);
    check_eq("epop_dout", d_out, 0);
    push(8'h5A);
    check_eq("epop_head", d_out, 8'h5A);
    pop_one();
    check_eq("epop_empty", data_valid, 0);

    // Reset mid-operation: 5 bytes queued with overflow set
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    push(8'hEE);
    for (int i = 0; i < 11; i++) pop_one();
    check_eq("pre_rst_head", d_out, 8'h8B);
    check_eq("pre_rst_ovf", overflow, 1);
    reset   = 1'b1;
    rx_done = 1'b1;
    d_in    = 8'hCC;
    rd_en   = 1'b1;
    tick();
    reset   = 1'b0;
    rx_done = 1'b0;
    rd_en   = 1'b0;
    check_eq("mr_dv", data_valid, 0);
    check_eq("mr_full", full, 0);
    check_eq("mr_ovf", overflow, 0);
    check_eq("mr_dout", d_out, 0);
`ifdef RX_FIFO_LEVEL_EN
    check_eq("mr_lvl", level, 0);
    check_eq("mr_af", almost_full, 0);
`endif
    push(8'h3C);
    check_eq("post_rst_head", d_out, 8'h3C);
    check_eq("post_rst_dv", data_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
